// File: rtl/sevenseg_arb_pkg.sv
// Shared definitions for the seven-segment display arbiter.
//   DIGIT_OFF        : nibble value the driver renders as a dark digit
//   state_e          : arbiter FSM states
//   rr_onehot_to_idx : binary index of a one-hot vector (up to 8 bits)
package sevenseg_arb_pkg;

   localparam logic [3:0] DIGIT_OFF = 4'd15;

   typedef enum logic [1:0] {StIdle, StGrant, StBlank} state_e;

   // OR-encode: for a one-hot input each set bit contributes its own index.
   function automatic logic [2:0] rr_onehot_to_idx(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sevenseg_display_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req      in  N_REQ        request vector
//   last_idx in  clog2(N_REQ) index of the most recent owner
//   valid    out 1            at least one request is set
//   win_idx  out clog2(N_REQ) first requester at or after last_idx+1 (wrapping)
module rr_picker #(
   parameter int unsigned N_REQ = 3
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_idx,
   output logic                     valid,
   output logic [$clog2(N_REQ)-1:0] win_idx
);

   localparam int unsigned IdxW = $clog2(N_REQ);

   int unsigned cand;

   always_comb begin
      valid   = 1'b0;
      win_idx = '0;
      cand    = 0;
      // Offset 1..N_REQ so the previous owner is checked last.
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = (32'(last_idx) + i) % N_REQ;
         if (!valid && req[cand[IdxW-1:0]]) begin
            valid   = 1'b1;
            win_idx = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/sevenseg_display_arbiter.sv
// Shares one 4-digit seven-segment display between N_REQ requesters.
// Round-robin ownership with a minimum hold time and a blank gap between owners.
//   clk, rst_n         clock, synchronous active-low reset
//   req                per-requester level request
//   req_en             per-requester display enable
//   req_digits         16 bits per requester, {d3,d2,d1,d0}
//   grant              one-hot owner, zero when unowned
//   busy               high while granted or blanking
//   en, digit_0..3     registered feed to the seven-segment driver
module sevenseg_display_arbiter
   import sevenseg_arb_pkg::*;
#(
   parameter int unsigned N_REQ        = 3,
   parameter int unsigned HOLD_CYCLES  = 100_000_000,
   parameter int unsigned BLANK_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     req_en,
   input  logic [16*N_REQ-1:0]  req_digits,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 en,
   output logic [3:0]           digit_0,
   output logic [3:0]           digit_1,
   output logic [3:0]           digit_2,
   output logic [3:0]           digit_3
);

   localparam int unsigned IdxW   = $clog2(N_REQ);
   localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   localparam logic [HoldW-1:0]  HoldMax  = HoldW'(HOLD_CYCLES - 1);
   localparam logic [BlankW-1:0] BlankMax = BlankW'(BLANK_CYCLES - 1);
   localparam logic [N_REQ-1:0]  OneLsb   = N_REQ'(1);
   localparam logic [15:0]       WordOff  = {4{DIGIT_OFF}};

   state_e              state_q, state_d;
   logic [HoldW-1:0]    hold_q, hold_d;
   logic [BlankW-1:0]   blank_q, blank_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic                busy_q, busy_d;
   logic                en_q, en_d;
   logic [15:0]         digits_q, digits_d;

   logic [15:0]         req_word [N_REQ];
   logic                pick_valid;
   logic [IdxW-1:0]     pick_idx;
   logic [IdxW-1:0]     owner_idx;
   logic                hold_done;
   logic                owner_req;
   logic                others_req;

   for (genvar i = 0; i < N_REQ; i++) begin : g_word
      assign req_word[i] = req_digits[16*i +: 16];
   end

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req      (req),
      .last_idx (last_q),
      .valid    (pick_valid),
      .win_idx  (pick_idx)
   );

   // The owner is recovered from the registered grant; no separate owner register.
   assign owner_idx  = IdxW'(rr_onehot_to_idx(8'(grant_q)));
   assign owner_req  = req[owner_idx];
   assign others_req = |(req & ~grant_q);
   assign hold_done  = (hold_q == HoldMax);

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      blank_d  = blank_q;
      last_d   = last_q;
      grant_d  = grant_q;
      en_d     = en_q;
      digits_d = digits_q;

      unique case (state_q)
         StIdle: begin
            grant_d  = '0;
            en_d     = 1'b0;
            digits_d = WordOff;
            if (pick_valid) begin
               state_d  = StGrant;
               hold_d   = '0;
               grant_d  = OneLsb << pick_idx;
               en_d     = req_en[pick_idx];
               digits_d = req_word[pick_idx];
            end
         end
         StGrant: begin
            if (!owner_req || (hold_done && others_req)) begin
               state_d  = StBlank;
               blank_d  = '0;
               last_d   = owner_idx;
               grant_d  = '0;
               en_d     = 1'b0;
               digits_d = WordOff;
            end else begin
               en_d     = req_en[owner_idx];
               digits_d = req_word[owner_idx];
               if (!hold_done) hold_d = hold_q + 1'b1;
            end
         end
         StBlank: begin
            if (blank_q == BlankMax) begin
               if (pick_valid) begin
                  state_d  = StGrant;
                  hold_d   = '0;
                  grant_d  = OneLsb << pick_idx;
                  en_d     = req_en[pick_idx];
                  digits_d = req_word[pick_idx];
               end else begin
                  state_d  = StIdle;
               end
            end else begin
               blank_d = blank_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         hold_q   <= '0;
         blank_q  <= '0;
         last_q   <= IdxW'(N_REQ - 1);
         grant_q  <= '0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         digits_q <= WordOff;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         blank_q  <= blank_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
         digits_q <= digits_d;
      end
   end

   assign grant   = grant_q;
   assign busy    = busy_q;
   assign en      = en_q;
   assign digit_0 = digits_q[3:0];
   assign digit_1 = digits_q[7:4];
   assign digit_2 = digits_q[11:8];
   assign digit_3 = digits_q[15:12];

endmodule

// File: doc/sevenseg_display_arbiter.md
# sevenseg_display_arbiter

Shares the single 4-digit seven-segment display between several requesters, for example a score readout, a timer and a debug view. It sits directly upstream of the seven-segment driver and supplies that driver's `en` and `digit_0..digit_3` inputs. Arbitration is round-robin with a guaranteed minimum display time per grant. Every change of owner passes through a short blank interval so one owner's digits are never mixed with another's.

## Interface

**Parameters**
- `N_REQ`, default 3: number of requesters, 2..8.
- `HOLD_CYCLES`, default 100_000_000: minimum grant duration in clk cycles (1 s at 100 MHz).
- `BLANK_CYCLES`, default 1_000_000: blank interval between owners (10 ms).

**Ports** (clock and reset first)
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  per-requester display request, level-sensitive.
- `req_en`  in  N_REQ  per-requester display enable, passed through while granted.
- `req_digits`  in  16*N_REQ  digits of requester i at [16i+15:16i], ordered {d3,d2,d1,d0}; each nibble is 0..9, or 15 for a blank digit.
- `grant`  out  N_REQ  one-hot current owner; all-zero when no one owns the display.
- `busy`  out  1  high in GRANT or BLANK.
- `en`  out  1  to the driver's `en`.
- `digit_0`, `digit_1`, `digit_2`, `digit_3`  out  4 each  to the driver's digit inputs.

## Operation

**States:** IDLE, GRANT, BLANK.

**IDLE**
- Outputs: `grant`=0, `en`=0, all digits=15.
- If any `req` bit is set, pick the winner with round-robin and enter GRANT.

**Round-robin rule**
- Search starts at index `last`+1 and wraps modulo N_REQ.
- `last` is the index of the most recent owner; its reset value is N_REQ-1, so requester 0 wins first after reset.

**GRANT**
- The hold counter counts up from 0 and saturates at HOLD_CYCLES-1.
- Each cycle, `en` and the digits are registered from the owner's `req_en` and `req_digits`.
- Go to BLANK when either condition holds:
  - the owner drops `req`, at any time, ignoring the hold; or
  - the hold has expired and any other `req` bit is set.
- If the hold has expired and only the owner is requesting, stay in GRANT indefinitely.

**BLANK**
- On entry: `grant`=0, `en`=0, digits=15, and `last` updates to the departing owner.
- Stay for exactly BLANK_CYCLES cycles.
- At the end, re-arbitrate using the `req` values of that final cycle:
  - a winner exists → GRANT;
  - no winner → IDLE.
- Requests that appear or drop during BLANK affect only that final arbitration.

**Width rules**
- Counter widths are $clog2(HOLD_CYCLES) and $clog2(BLANK_CYCLES).
- The nibbles pass through unmodified. Values 10..14 are not filtered; the driver shows them as its debug glyph.

**Reset**
- Takes effect on any clk edge while `rst_n`=0, regardless of state.
- Result: state IDLE, counters 0, `last`=N_REQ-1, `grant`=0, `busy`=0, `en`=0, digits=15.

## Timing

- All outputs are registered; none is combinational from an input.
- `req` rises in IDLE at edge k → `grant` and the first digits are valid after edge k+1.
- Owner data path: a change on `req_digits`/`req_en` at edge k appears on the outputs after edge k+1.
- Owner drops `req` at edge k → `grant`=0, `en`=0 after edge k+1.
- Blank length: BLANK entered after edge k → the next GRANT is visible after edge k+BLANK_CYCLES.
- Minimum grant with a competitor waiting: exactly HOLD_CYCLES cycles of `grant`.
- `grant` is never multi-hot.
- `grant` never moves directly from one owner to another; a BLANK interval always separates two owners.

## Structure

- **Package `sevenseg_arb_pkg`:**
  - `DIGIT_OFF` = 4'd15;
  - state enum {IDLE, GRANT, BLANK};
  - helper function `rr_onehot_to_idx`.
- **Sub-module `rr_picker`:** combinational round-robin picker.
  - Inputs: `req[N_REQ]`, `last_idx`.
  - Outputs: `valid`, `win_idx`.
  - Reused by any future shared-resource arbiters (LED bank, OLED).
- **Top level:** FSM, hold and blank counters, and the output registers.

## Test plan

All scenarios use N_REQ=3, HOLD_CYCLES=8, BLANK_CYCLES=3.

- **Reset.** Hold `rst_n`=0 for 2 cycles with `req`=3'b111 → `grant`=0, `en`=0, digits=F,F,F,F, `busy`=0. After release, `grant`=3'b001 one cycle later.
- **Single requester, hold.** `req`=3'b010 with digits 1,2,3,4 and `req_en`=1 → `grant`=010 and digits 1,2,3,4 after 1 cycle. Keep `req` high for 50 cycles → no BLANK ever occurs.
- **Hold then rotate.** Start with `req`=3'b001, then raise `req[2]` at grant cycle 2 → `grant`=001 for exactly 8 cycles, then 3 blank cycles, then `grant`=100.
- **Early release.** Owner 0 drops `req` at grant cycle 3 while `req[1]` is high → BLANK the next cycle (hold ignored), then `grant`=010 after 3 cycles.
- **Round-robin fairness.** `req`=3'b111 continuously for 60 cycles → grant sequence 001, 010, 100, 001, each grant 8 cycles, each gap 3 blank cycles.
- **Reset mid-operation.** Assert `rst_n`=0 during BLANK → IDLE on the next edge. After release, requester 0 wins again.
